float_mul_pipe: RTL and testbench
=================================

# float_mul_pipe

Parametrised, pipelined IEEE-754 floating-point multiplier. It is the successor to the single-precision combinational `float_mul` in the execution-unit set. Exponent and mantissa widths are configurable, so the same block serves binary16, binary32 and binary64 FMUL slots. It adds a valid/ready handshake, a 3-stage pipeline, round-to-nearest-even and sticky-free per-result exception flags, and sits behind the VLIW issue stage in each FMUL lane.

## Interface
- `EXP_W`, 8, exponent field width (≥3).
- `MAN_W`, 23, stored fraction width (≥2).
- `W`, derived local, `1+EXP_W+MAN_W`, total operand width.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_valid`  in  1  operands present on `num1`/`num2`.
- `in_ready`  out  1  block accepts operands this cycle.
- `num1`  in  W  operand A.
- `num2`  in  W  operand B.
- `out_valid`  out  1  `out`/`flags` hold a result.
- `out_ready`  in  1  consumer takes the result this cycle.
- `out`  out  W  product.
- `flags`  out  4  {invalid, overflow, underflow, inexact} for the current `out`.

## Operation
- Stage S1 (unpack/classify):
  - split sign, exponent and fraction;
  - classify each operand as zero, subnormal, normal, inf, qNaN or sNaN;
  - subnormal inputs are treated as signed zero (DAZ).
- Stage S2 (multiply):
  - `sign = s1 ^ s2`;
  - biased exponent sum `e1+e2-BIAS`, carried at width EXP_W+2, signed;
  - `(MAN_W+1)x(MAN_W+1)` significand product, 2·MAN_W+2 bits.
- Stage S3 (normalise/round/pack):
  - if product MSB is set, shift right 1 and increment exponent;
  - guard = first dropped bit; sticky = OR of the remaining dropped bits;
  - round to nearest, ties to even;
  - a rounding carry-out renormalises and increments the exponent.
- Special cases, in priority order:
  1. Any NaN operand gives canonical qNaN (sign 0, exp all-ones, fraction MSB 1, rest 0). `invalid` is set only if an operand is sNaN.
  2. inf × zero gives canonical qNaN with `invalid` set.
  3. inf × anything else gives signed inf, no flags.
  4. zero × finite gives signed zero, no flags.
- Overflow (rounded exponent ≥ all-ones): signed inf, `overflow` and `inexact` set.
- Underflow (rounded exponent ≤ 0): signed zero (FTZ), `underflow` and `inexact` set.
- `inexact` is set whenever guard or sticky is nonzero on a finite normal result.
- Flags describe only the result they accompany. No accumulation across results.

## Timing
- Latency: 3 cycles from input acceptance to `out_valid` with no stall. Throughput is 1 result per cycle.
- Handshake:
  - Input is accepted on a rising edge when `in_valid && in_ready`.
  - Output is consumed on a rising edge when `out_valid && out_ready`.
  - `in_valid`, `num1` and `num2` need not stay stable while `in_ready` is low.
- Stall rule:
  - each stage register loads when it is empty or its downstream stage advances;
  - `in_ready = !S1_valid || S1_advance`;
  - bubbles collapse, so a full pipe under `out_ready` = 0 holds 3 results and then drops `in_ready` in the same cycle.
- While `out_valid=1 && out_ready=0`, `out` and `flags` stay stable.
- `in_ready` is combinational from `out_ready` and the stage valids. There is no combinational path from `num1`/`num2` to any output.
- Reset (`rst_n` low, at any time including mid-operation):
  - all stage valids go to 0 immediately;
  - `out` = 0, `flags` = 0;
  - in-flight operations are discarded;
  - `in_ready` = 1 while in reset and on the first edge after release.
- Simultaneous accept and emit in one cycle is legal and required for full throughput.

## Test plan
- Normal results, default params, back-to-back inputs with `out_ready` = 1:
  - 0x40000000 × 0x447A0000 → 0x44FA0000;
  - 0x41200000 × 0xC2C60000 → 0xC4778000;
  - `flags` = 0;
  - results emerge on consecutive cycles, 3 cycles after each accept.
- Special cases:
  - 0x7F800000 × 0x01E51000 → 0x7F800000, flags 0;
  - 0x00000000 × 0x7F800000 → 0x7FC00000 with `invalid`;
  - 0x7FC00002 × 0x18010E00 → 0x7FC00000, flags 0;
  - 0x7F800001 × 0x3F800000 → 0x7FC00000 with `invalid`.
- Range and rounding:
  - 0x7F000000 × 0x7F000000 → 0x7F800000 with `overflow` and `inexact`;
  - 0x00800000 × 0x3F000000 → 0x00000000 with `underflow` and `inexact`;
  - 0x3F800001 × 0x3F800001 → 0x3F800002 with `inexact`;
  - 0x00400000 (subnormal) × 0x40000000 → 0x00000000, flags 0.
- Backpressure:
  - issue 5 operations, hold `out_ready` = 0 from cycle 2;
  - `in_ready` drops after exactly 3 accepts;
  - `out` stays stable;
  - release gives all 5 results in order with no loss or duplication.
- Reset mid-flight: assert `rst_n` low asynchronously with 3 operations in flight → `out_valid` = 0, `out` = 0 and `flags` = 0 immediately, and no stale result appears after release.
- EXP_W=5, MAN_W=10 instance:
  - 0x4000 × 0x3C00 → 0x4000;
  - 0x7BFF × 0x4000 → 0x7C00 with `overflow` and `inexact`;
  - 0xFC00 × 0x0000 → 0x7E00 with `invalid`.

Source files
------------

// File: rtl/float_mul_if.sv
// float_mul_if: operand/result handshake bundle for float_mul_pipe.
interface float_mul_if #(parameter int EXP_W = 8, parameter int MAN_W = 23);
   localparam int W = 1 + EXP_W + MAN_W;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] num1;
   logic [W-1:0] num2;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out;
   logic [3:0]   flags;
   modport master (output in_valid, num1, num2, out_ready, input in_ready, out_valid, out, flags);
   modport slave (input in_valid, num1, num2, out_ready, output in_ready, out_valid, out, flags);
endinterface

// File: rtl/float_mul_pipe.sv
// float_mul_pipe: 3-stage IEEE-754 multiplier, RNE, DAZ/FTZ, per-result {invalid,overflow,underflow,inexact}.
module float_mul_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input logic       clk,
   input logic       rst_n,
   float_mul_if.slave bus
);
   localparam int W = 1 + EXP_W + MAN_W;
   localparam logic [EXP_W+1:0] BIAS = (EXP_W+2)'(2**(EXP_W-1) - 1);
   localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] e1, e2;
      logic [MAN_W:0]   m1, m2;
      logic             nan, inv, inf, zero;
   } s1_t;
   typedef struct packed {
      logic               sign;
      logic [EXP_W+1:0]   ex;
      logic [2*MAN_W+1:0] prod;
      logic               nan, inv, inf, zero;
   } s2_t;
   typedef struct packed {
      logic [W-1:0] res;
      logic [3:0]   flags;
   } s3_t;
   s1_t s1_q, s1_d, nx1;
   s2_t s2_q, s2_d, nx2;
   s3_t s3_q, s3_d, nx3;
   logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, ld1, ld2, ld3;
   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] fa, fb;
   logic za, zb, ia, ib, na, nb, sa, sb;
   logic msb, g, st, up, ovf, unf;
   logic [2*MAN_W-1:0] pn;
   logic [EXP_W+1:0] en, er;
   logic [MAN_W:0] fr;
   always_comb begin
      ea = bus.num1[W-2:MAN_W];
      fa = bus.num1[MAN_W-1:0];
      eb = bus.num2[W-2:MAN_W];
      fb = bus.num2[MAN_W-1:0];
      // zero exponent covers subnormals too, so they collapse to signed zero
      za = ea == '0;
      zb = eb == '0;
      ia = &ea && fa == '0;
      ib = &eb && fb == '0;
      na = &ea && fa != '0;
      nb = &eb && fb != '0;
      sa = na && !fa[MAN_W-1];
      sb = nb && !fb[MAN_W-1];
      nx1.sign = bus.num1[W-1] ^ bus.num2[W-1];
      nx1.e1 = ea;
      nx1.e2 = eb;
      nx1.m1 = {1'b1, fa};
      nx1.m2 = {1'b1, fb};
      nx1.nan = na || nb || (ia && zb) || (za && ib);
      nx1.inv = sa || sb || (ia && zb) || (za && ib);
      nx1.inf = ia || ib;
      nx1.zero = za || zb;
      nx2.sign = s1_q.sign;
      nx2.ex = {2'b0, s1_q.e1} + {2'b0, s1_q.e2} - BIAS;
      nx2.prod = {{(MAN_W+1){1'b0}}, s1_q.m1} * {{(MAN_W+1){1'b0}}, s1_q.m2};
      nx2.nan = s1_q.nan;
      nx2.inv = s1_q.inv;
      nx2.inf = s1_q.inf;
      nx2.zero = s1_q.zero;
      // pn holds the fraction followed by the guard and sticky candidates after normalising
      msb = s2_q.prod[2*MAN_W+1];
      pn = msb ? s2_q.prod[2*MAN_W:1] : s2_q.prod[2*MAN_W-1:0];
      en = s2_q.ex + {{(EXP_W+1){1'b0}}, msb};
      g = pn[MAN_W-1];
      st = |pn[MAN_W-2:0] || (msb && s2_q.prod[0]);
      up = g && (st || pn[MAN_W]);
      fr = {1'b0, pn[2*MAN_W-1:MAN_W]} + {{MAN_W{1'b0}}, up};
      er = en + {{(EXP_W+1){1'b0}}, fr[MAN_W]};
      ovf = !er[EXP_W+1] && (er[EXP_W] || &er[EXP_W-1:0]);
      unf = er[EXP_W+1] || er == '0;
      nx3.res = s2_q.nan ? QNAN :
                (s2_q.inf || (!s2_q.zero && ovf)) ? {s2_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
                (s2_q.zero || unf) ? {s2_q.sign, {(W-1){1'b0}}} :
                {s2_q.sign, er[EXP_W-1:0], fr[MAN_W-1:0]};
      nx3.flags = s2_q.nan ? {s2_q.inv, 3'b000} :
                  (s2_q.inf || s2_q.zero) ? 4'b0000 :
                  ovf ? 4'b0101 : unf ? 4'b0011 : {3'b000, g || st};
      ld3 = !v3_q || bus.out_ready;
      ld2 = !v2_q || ld3;
      ld1 = !v1_q || ld2;
      v1_d = ld1 ? bus.in_valid : v1_q;
      v2_d = ld2 ? v1_q : v2_q;
      v3_d = ld3 ? v2_q : v3_q;
      s1_d = (ld1 && bus.in_valid) ? nx1 : s1_q;
      s2_d = (ld2 && v1_q) ? nx2 : s2_q;
      s3_d = (ld3 && v2_q) ? nx3 : s3_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         v3_q <= 1'b0;
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
      end else begin
         v1_q <= v1_d;
         v2_q <= v2_d;
         v3_q <= v3_d;
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
      end
   end
   assign bus.in_ready = ld1;
   assign bus.out_valid = v3_q;
   assign bus.out = s3_q.res;
   assign bus.flags = s3_q.flags;
endmodule

// File: tb/tb_float_mul_pipe.sv
// tb_float_mul_pipe: scoreboard bench for binary32 and binary16 instances of float_mul_pipe.
module tb_float_mul_pipe;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;
   float_mul_if #(.EXP_W(8), .MAN_W(23)) b32 ();
   float_mul_if #(.EXP_W(5), .MAN_W(10)) b16 ();
   float_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
   float_mul_pipe #(.EXP_W(5), .MAN_W(10)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16.slave));
   typedef struct {
      logic [35:0] v;
      int          c;
      bit          lat;
   } exp_t;
   exp_t q32[$];
   logic [19:0] q16[$];
   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   logic [31:0] opa[12] = '{32'h40000000, 32'h41200000, 32'h7F800000, 32'h00000000, 32'h7FC00002, 32'h7F800001,
                            32'h7F000000, 32'h00800000, 32'h3F800001, 32'h00400000, 32'h80000000, 32'hFF800000};
   logic [31:0] opb[12] = '{32'h447A0000, 32'hC2C60000, 32'h01E51000, 32'h7F800000, 32'h18010E00, 32'h3F800000,
                            32'h7F000000, 32'h3F000000, 32'h3F800001, 32'h40000000, 32'h3F800000, 32'h40000000};
   logic [31:0] res[12] = '{32'h44FA0000, 32'hC4778000, 32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000,
                            32'h7F800000, 32'h00000000, 32'h3F800002, 32'h00000000, 32'h80000000, 32'hFF800000};
   logic [3:0]  flg[12] = '{4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h8, 4'h5, 4'h3, 4'h1, 4'h0, 4'h0, 4'h0};
   logic [15:0] ha[3] = '{16'h4000, 16'h7BFF, 16'hFC00};
   logic [15:0] hb[3] = '{16'h3C00, 16'h4000, 16'h0000};
   logic [15:0] hr[3] = '{16'h4000, 16'h7C00, 16'h7E00};
   logic [3:0]  hf[3] = '{4'h0, 4'h5, 4'h8};
   always @(posedge clk) cyc <= cyc + 1;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask
   task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic [35:0] r, input bit lat);
      int t = 0;
      b32.in_valid = 1'b1;
      b32.num1 = a;
      b32.num2 = b;
      @(negedge clk);
      while (!b32.in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!b32.in_ready) check("accept32", b32.in_ready, 1'b1);
      else q32.push_back('{r, cyc, lat});
      @(posedge clk);
      #1;
   endtask
   task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic [19:0] r);
      int t = 0;
      b16.in_valid = 1'b1;
      b16.num1 = a;
      b16.num2 = b;
      @(negedge clk);
      while (!b16.in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!b16.in_ready) check("accept16", b16.in_ready, 1'b1);
      else q16.push_back(r);
      @(posedge clk);
      #1;
   endtask
   always @(negedge clk) begin
      if (rst_n && b32.out_valid && b32.out_ready) begin : mon32
         exp_t e;
         if (q32.size() == 0) check("spurious32", b32.out_valid, 1'b0);
         else begin
            e = q32.pop_front();
            check("res32", {b32.out, b32.flags}, e.v);
            if (e.lat) check("lat32", cyc - e.c, 3);
         end
      end
      if (rst_n && b16.out_valid && b16.out_ready) begin
         if (q16.size() == 0) check("spurious16", b16.out_valid, 1'b0);
         else check("res16", {b16.out, b16.flags}, q16.pop_front());
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int idx;
      int t;
      b32.in_valid = 1'b0;
      b32.num1 = '0;
      b32.num2 = '0;
      b32.out_ready = 1'b1;
      b16.in_valid = 1'b0;
      b16.num1 = '0;
      b16.num2 = '0;
      b16.out_ready = 1'b1;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", b32.out_valid, 1'b0);
      check("rst_out", b32.out, 32'h0);
      check("rst_flags", b32.flags, 4'h0);
      check("rst_in_ready", b32.in_ready, 1'b1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 12; i++) send32(opa[i], opb[i], {res[i], flg[i]}, 1'b1);
      b32.in_valid = 1'b0;
      for (int i = 0; i < 3; i++) send16(ha[i], hb[i], {hr[i], hf[i]});
      b16.in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("drain_normal32", q32.size(), 0);
      check("drain_half16", q16.size(), 0);
      // backpressure: pipe must absorb exactly three operations, then stall
      b32.out_ready = 1'b0;
      b32.in_valid = 1'b1;
      idx = 0;
      for (int k = 0; k < 8; k++) begin
         b32.num1 = opa[idx];
         b32.num2 = opb[idx];
         @(negedge clk);
         if (b32.in_ready) begin
            q32.push_back('{{res[idx], flg[idx]}, cyc, 1'b0});
            idx++;
         end
         @(posedge clk);
         #1;
      end
      check("bp_accepts", idx, 3);
      check("bp_in_ready", b32.in_ready, 1'b0);
      check("bp_valid", b32.out_valid, 1'b1);
      for (int k = 0; k < 3; k++) begin
         check("bp_hold", {b32.out, b32.flags}, {res[0], flg[0]});
         @(posedge clk);
         #1;
      end
      b32.out_ready = 1'b1;
      t = 0;
      while (idx < 5 && t < 50) begin
         b32.num1 = opa[idx];
         b32.num2 = opb[idx];
         @(negedge clk);
         if (b32.in_ready) begin
            q32.push_back('{{res[idx], flg[idx]}, cyc, 1'b0});
            idx++;
         end
         @(posedge clk);
         #1;
         t++;
      end
      b32.in_valid = 1'b0;
      check("bp_total", idx, 5);
      repeat (8) @(posedge clk);
      #1;
      check("bp_drain", q32.size(), 0);
      // asynchronous reset with a full pipe discards everything
      b32.out_ready = 1'b0;
      send32(opa[0], opb[0], {res[0], flg[0]}, 1'b0);
      send32(opa[1], opb[1], {res[1], flg[1]}, 1'b0);
      send32(opa[8], opb[8], {res[8], flg[8]}, 1'b0);
      b32.in_valid = 1'b0;
      check("pre_rst_valid", b32.out_valid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", b32.out_valid, 1'b0);
      check("mid_rst_out", b32.out, 32'h0);
      check("mid_rst_flags", b32.flags, 4'h0);
      check("mid_rst_in_ready", b32.in_ready, 1'b1);
      q32.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      b32.out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("post_rst_idle", b32.out_valid, 1'b0);
      end
      @(posedge clk);
      #1;
      send32(opa[1], opb[1], {res[1], flg[1]}, 1'b1);
      b32.in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("post_rst_drain", q32.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
